// File: rtl/cache.sv
// Set-associative LLC tag/state store: MESI state per line, tree-PLRU per set,
// single-cycle lookup/update with a registered response strobe.
package cache_pkg;
  typedef enum logic [1:0] {
    I = 2'b00,
    S = 2'b01,
    E = 2'b10,
    M = 2'b11
  } mesi_e;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_INVAL = 2'b10;
  localparam logic [1:0] OP_SNOOP = 2'b11;
endpackage

module cache
  import cache_pkg::*;
#(
  parameter int ADDR_SIZE   = 32,
  parameter int BYTE_OFFSET = 6,
  parameter int INDEX_SIZE  = 14,
  parameter int N_WAY       = 16,
  localparam int NUM_SETS   = 2**INDEX_SIZE,
  localparam int TAG_SIZE   = ADDR_SIZE - INDEX_SIZE - BYTE_OFFSET,
  localparam int WAY_W      = $clog2(N_WAY)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_SIZE-1:0]  address,
  output logic [INDEX_SIZE-1:0] index,
  output logic [TAG_SIZE-1:0]   tag,
  input  logic                  req_valid,
  input  logic [1:0]            req_op,
  input  logic                  shared_in,
  output logic                  rsp_valid,
  output logic                  hit,
  output logic [WAY_W-1:0]      way,
  output mesi_e                 mesi_out,
  output logic                  evict,
  output logic                  writeback
);

  typedef struct packed {
    logic                valid;
    logic [TAG_SIZE-1:0] tag;
    mesi_e               mesi;
  } way_t;

  typedef struct packed {
    way_t [N_WAY-1:0]   ways;
    logic [N_WAY-2:0]   plru_bits;
  } set_t;

  set_t cache_mem [NUM_SETS];

  logic                 rsp_valid_q, rsp_valid_d;
  logic                 hit_q, hit_d;
  logic [WAY_W-1:0]     way_q, way_d;
  mesi_e                mesi_q, mesi_d;
  logic                 evict_q, evict_d;
  logic                 wb_q, wb_d;

  set_t                 cur_set;
  set_t                 set_d;
  logic                 lookup_hit;
  logic [WAY_W-1:0]     hit_way;
  logic [WAY_W-1:0]     victim_way;
  logic                 free_found;
  logic                 touch;
  logic [WAY_W-1:0]     touch_way;

  logic unused_offset;
  assign unused_offset = ^address[BYTE_OFFSET-1:0];

  assign index = address[BYTE_OFFSET+INDEX_SIZE-1:BYTE_OFFSET];
  assign tag   = address[ADDR_SIZE-1:ADDR_SIZE-TAG_SIZE];

  task automatic initialize_cache();
    cache_mem <= '{default: '0};
  endtask

  // Walk the tree from the root: a 0 node points left, a 1 node points right.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [N_WAY-2:0] bits);
    logic [WAY_W-1:0] node;
    logic [WAY_W-1:0] wv;
    node = '0;
    wv   = '0;
    for (int l = 0; l < WAY_W; l++) begin
      wv   = (wv << 1) | WAY_W'(bits[node]);
      node = (node << 1) + WAY_W'(1) + WAY_W'(bits[node]);
    end
    return wv;
  endfunction

  // Mark every node on the accessed way's path to point at the other subtree.
  function automatic logic [N_WAY-2:0] plru_touch(input logic [N_WAY-2:0] bits,
                                                  input logic [WAY_W-1:0] w);
    logic [N_WAY-2:0] nb;
    logic [WAY_W-1:0] node;
    logic [WAY_W-1:0] wv;
    logic             dir;
    nb   = bits;
    node = '0;
    wv   = w;
    for (int l = 0; l < WAY_W; l++) begin
      dir      = wv[WAY_W-1];
      wv       = wv << 1;
      nb[node] = ~dir;
      node     = (node << 1) + WAY_W'(1) + WAY_W'(dir);
    end
    return nb;
  endfunction

  assign cur_set = cache_mem[index];

  always_comb begin
    lookup_hit = 1'b0;
    hit_way    = '0;
    free_found = 1'b0;
    victim_way = '0;
    for (int w = 0; w < N_WAY; w++) begin
      if (!lookup_hit && cur_set.ways[w].valid && cur_set.ways[w].tag == tag &&
          cur_set.ways[w].mesi != I) begin
        lookup_hit = 1'b1;
        hit_way    = WAY_W'(w);
      end
      if (!free_found && !cur_set.ways[w].valid) begin
        free_found = 1'b1;
        victim_way = WAY_W'(w);
      end
    end
    if (!free_found) victim_way = plru_victim(cur_set.plru_bits);
  end

  always_comb begin
    set_d       = cur_set;
    rsp_valid_d = req_valid;
    hit_d       = 1'b0;
    way_d       = '0;
    mesi_d      = I;
    evict_d     = 1'b0;
    wb_d        = 1'b0;
    touch       = 1'b0;
    touch_way   = '0;
    if (req_valid) begin
      hit_d = lookup_hit;
      if (lookup_hit) begin
        way_d  = hit_way;
        mesi_d = cur_set.ways[hit_way].mesi;
        unique case (req_op)
          OP_READ: begin
            touch     = 1'b1;
            touch_way = hit_way;
          end
          OP_WRITE: begin
            set_d.ways[hit_way].mesi = M;
            mesi_d    = M;
            touch     = 1'b1;
            touch_way = hit_way;
          end
          OP_INVAL: begin
            set_d.ways[hit_way].mesi  = I;
            set_d.ways[hit_way].valid = 1'b0;
            mesi_d = I;
          end
          OP_SNOOP: begin
            if (cur_set.ways[hit_way].mesi inside {M, E}) begin
              set_d.ways[hit_way].mesi = S;
              mesi_d = S;
            end
            wb_d = (cur_set.ways[hit_way].mesi == M);
          end
          default: ;
        endcase
      end else if (req_op == OP_READ || req_op == OP_WRITE) begin
        // Allocation: report what the victim held before it is overwritten.
        way_d     = victim_way;
        evict_d   = cur_set.ways[victim_way].valid;
        wb_d      = cur_set.ways[victim_way].valid && (cur_set.ways[victim_way].mesi == M);
        if (req_op == OP_WRITE) mesi_d = M;
        else                    mesi_d = shared_in ? S : E;
        set_d.ways[victim_way].valid = 1'b1;
        set_d.ways[victim_way].tag   = tag;
        set_d.ways[victim_way].mesi  = mesi_d;
        touch     = 1'b1;
        touch_way = victim_way;
      end
      if (touch) set_d.plru_bits = plru_touch(cur_set.plru_bits, touch_way);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_mem <= '{default: '0};
    end else if (req_valid) begin
      cache_mem[index] <= set_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      way_q       <= '0;
      mesi_q      <= I;
      evict_q     <= 1'b0;
      wb_q        <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      hit_q       <= hit_d;
      way_q       <= way_d;
      mesi_q      <= mesi_d;
      evict_q     <= evict_d;
      wb_q        <= wb_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign hit       = hit_q;
  assign way       = way_q;
  assign mesi_out  = mesi_q;
  assign evict     = evict_q;
  assign writeback = wb_q;

endmodule

// File: tb/tb_cache.sv
// Scoreboard bench for the cache tag/state store: directed requests push
// hand-computed responses; a monitor pops and compares on every rsp_valid.
module tb_cache;
  import cache_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] address;
  logic [13:0] index;
  logic [11:0] tag;
  logic        req_valid;
  logic [1:0]  req_op;
  logic        shared_in;
  logic        rsp_valid;
  logic        hit;
  logic [3:0]  way;
  mesi_e       mesi_out;
  logic        evict;
  logic        writeback;

  cache dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .address   (address),
    .index     (index),
    .tag       (tag),
    .req_valid (req_valid),
    .req_op    (req_op),
    .shared_in (shared_in),
    .rsp_valid (rsp_valid),
    .hit       (hit),
    .way       (way),
    .mesi_out  (mesi_out),
    .evict     (evict),
    .writeback (writeback)
  );

  typedef struct packed {
    logic       h;
    logic [3:0] w;
    logic [1:0] m;
    logic       ev;
    logic       wb;
  } rsp_t;

  rsp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, want);
  endtask

  task automatic issue(input logic [31:0] a, input logic [1:0] op, input logic sh,
                       input logic h, input int w, input mesi_e m,
                       input logic ev, input logic wb, input string nm);
    rsp_t  r;
    int    wi;
    @(negedge clk);
    address   = a;
    req_op    = op;
    shared_in = sh;
    req_valid = 1'b1;
    wi        = w;
    r.h  = h;
    r.w  = wi[3:0];
    r.m  = m;
    r.ev = ev;
    r.wb = wb;
    exp_q.push_back(r);
    name_q.push_back(nm);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  // Monitor: every response strobe pops one expected entry.
  initial begin
    rsp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response");
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if ({hit, way, mesi_out, evict, writeback} === e) n_pass++;
          else $display("FAIL %s: got hit=%0d way=%0d mesi=%0d evict=%0d wb=%0d, expected hit=%0d way=%0d mesi=%0d evict=%0d wb=%0d",
                        nm, hit, way, mesi_out, evict, writeback, e.h, e.w, e.m, e.ev, e.wb);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] fill_addr(input int t);
    logic [31:0] tv;
    tv = t;
    return {tv[11:0], 20'h01000};
  endfunction

  initial begin
    int bad;
    logic [13:0] si;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = OP_READ;
    shared_in = 1'b0;
    address   = 32'hFFFF_8000;
    #1;
    check("idx_in_reset", {18'd0, index}, 32'h3E00);
    check("tag_in_reset", {20'd0, tag}, 32'hFFF);
    address = 32'h0000_1000;
    #1;
    check("idx_1000", {18'd0, index}, 32'h040);
    check("tag_1000", {20'd0, tag}, 32'h000);
    repeat (3) @(negedge clk);
    check("idle_outputs", {26'd0, rsp_valid, hit, way, evict, writeback},
          32'd0);
    check("idle_mesi", {30'd0, mesi_out}, {30'd0, I});
    rst_n = 1'b1;
    @(negedge clk);

    bad = 0;
    for (int s = 0; s < 16384; s++) begin
      si = s[13:0];
      if (dut.cache_mem[si] !== '0) bad++;
    end
    check("reset_scan_bad_sets", bad, 0);

    issue(32'h0000_1000, OP_READ,  1'b1, 1'b0, 0, S, 1'b0, 1'b0, "rd_miss_shared");
    issue(32'h0000_1000, OP_READ,  1'b1, 1'b1, 0, S, 1'b0, 1'b0, "rd_hit_S");
    issue(32'h0000_2000, OP_WRITE, 1'b0, 1'b0, 0, M, 1'b0, 1'b0, "wr_miss");
    issue(32'h0000_2000, OP_SNOOP, 1'b0, 1'b1, 0, S, 1'b0, 1'b1, "snoop_M");
    issue(32'hFFFF_8000, OP_READ,  1'b0, 1'b0, 0, E, 1'b0, 1'b0, "rd_miss_excl");
    issue(32'hFFFF_8000, OP_INVAL, 1'b0, 1'b1, 0, I, 1'b0, 1'b0, "inval_hit");
    issue(32'hFFFF_8000, OP_READ,  1'b0, 1'b0, 0, E, 1'b0, 1'b0, "rd_after_inval");
    issue(32'h0000_3000, OP_READ,  1'b1, 1'b0, 0, S, 1'b0, 1'b0, "rd_miss_S_3000");
    issue(32'h0000_3000, OP_WRITE, 1'b0, 1'b1, 0, M, 1'b0, 1'b0, "wr_hit_S_to_M");
    issue(32'h0000_5000, OP_SNOOP, 1'b0, 1'b0, 0, I, 1'b0, 1'b0, "snoop_miss");
    issue(32'h0000_5000, OP_INVAL, 1'b0, 1'b0, 0, I, 1'b0, 1'b0, "inval_miss");
    idle(2);
    check("snoop_miss_no_alloc", {31'd0, dut.cache_mem[14'h140].ways[0].valid}, 32'd0);

    // Free way 0 of set 0x040, then fill ways 0..15 with tags 1..16.
    issue(32'h0000_1000, OP_INVAL, 1'b0, 1'b1, 0, I, 1'b0, 1'b0, "inval_1000");
    for (int t = 1; t <= 16; t++)
      issue(fill_addr(t), OP_READ, 1'b0, 1'b0, t - 1, E, 1'b0, 1'b0, $sformatf("fill_%0d", t));
    issue(fill_addr(1),  OP_READ, 1'b0, 1'b1, 0,  E, 1'b0, 1'b0, "touch_way0");
    issue(fill_addr(17), OP_READ, 1'b0, 1'b0, 8,  E, 1'b1, 1'b0, "evict_plru_way8");
    issue(fill_addr(1),  OP_READ, 1'b0, 1'b1, 0,  E, 1'b0, 1'b0, "way0_retained");
    issue(fill_addr(9),  OP_READ, 1'b0, 1'b0, 12, E, 1'b1, 1'b0, "evict_plru_way12");
    issue(fill_addr(17), OP_WRITE, 1'b0, 1'b1, 8, M, 1'b0, 1'b0, "wr_hit_E_to_M");
    idle(3);
    check("way0_tag_hier", {20'd0, dut.cache_mem[14'h040].ways[0].tag}, 32'h001);
    check("way8_tag_hier", {20'd0, dut.cache_mem[14'h040].ways[8].tag}, 32'h011);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cache.md
Name: cache

Overview:
- Set-associative last-level cache tag/state store with MESI coherence state per line and tree pseudo-LRU (PLRU) replacement per set.
- Splits a request address into index and tag, performs a tag lookup on each request, and updates valid/tag/MESI/PLRU state.
- Reports hit, miss, victim and writeback information to the surrounding simulator/controller.
- Constants and the MESI enum (M, E, S, I) come from the shared line package.

Parameters:
- ADDR_SIZE, 32, request address width.
- BYTE_OFFSET, 6, line-offset bits (64-byte lines).
- INDEX_SIZE, 14, set-index width.
- N_WAY, 16, associativity (power of two).
- NUM_SETS, 2**INDEX_SIZE, derived; not overridable.
- TAG_SIZE, ADDR_SIZE-INDEX_SIZE-BYTE_OFFSET, derived (12).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- address  in  ADDR_SIZE  request address.
- index  out  INDEX_SIZE  address[BYTE_OFFSET+INDEX_SIZE-1:BYTE_OFFSET], combinational.
- tag  out  TAG_SIZE  address[ADDR_SIZE-1:ADDR_SIZE-TAG_SIZE], combinational.
- req_valid  in  1  request strobe, one cycle per request.
- req_op  in  2  00 read, 01 write, 10 invalidate, 11 snoop-read.
- shared_in  in  1  another cache holds the line; sampled with a read request.
- rsp_valid  out  1  response strobe.
- hit  out  1  tag match on a valid line.
- way  out  $clog2(N_WAY)  hit way or allocated way.
- mesi_out  out  2  MESI state of that way after the update.
- evict  out  1  a valid victim line was replaced.
- writeback  out  1  the evicted victim was in state M.

Behaviour:
- Storage is an internal array named cache_mem[NUM_SETS]; each set holds ways[N_WAY] entries plus plru_bits[N_WAY-1].
  - Each way has valid, tag[TAG_SIZE] and mesi (mesi_e).
  - The array is hierarchically readable and writable by benches.
- Void task initialize_cache(): sets every valid=0, tag=0, mesi=I and every plru_bits='0. It may be called at time 0.
- Reset (rst_n low, asynchronous): same clearing as initialize_cache.
  - rsp_valid, hit, evict, writeback and way are 0; mesi_out is I.
  - Reset asserted mid-request drops that request; no response is issued.
- index and tag are purely combinational from address at all times, including during reset.
- Latency: a request sampled at edge N produces a rsp_valid pulse for exactly one cycle after edge N.
  - The state update is committed at edge N.
  - Back-to-back requests are accepted every cycle.
- Lookup: hit when some way in set index has valid=1, a matching tag and mesi != I.
- Read:
  - hit: MESI unchanged.
  - miss: allocate the victim; new state is S if shared_in=1, else E.
- Write:
  - hit: the way becomes M from S, E or M.
  - miss: allocate the victim with state M.
- Invalidate:
  - hit: mesi=I, valid=0; PLRU is not updated.
  - miss: no state change, hit=0.
- Snoop-read:
  - hit in M or E: becomes S; writeback=1 if the line was M.
  - hit in S: unchanged.
  - miss: no change; no allocation, no PLRU update.
- Victim selection: the lowest-numbered way with valid=0; if all ways are valid, the way pointed to by the PLRU tree.
  - Tree walk: bit 0 is the root; node bit 0 goes left, 1 goes right; children of node k are 2k+1 and 2k+2.
- PLRU update on every read/write hit or allocation: set the nodes along the path to point away from the accessed way.
- On allocation: evict=valid of the victim; writeback=1 when the victim mesi was M. Tag, valid=1 and mesi are overwritten.
- On a miss without allocation, way reports 0 and mesi_out reports I.

Test Plan:
- Reset, then scan all sets: every valid=0, tag=0, mesi=I, plru_bits=0; outputs idle.
- address=0x0000_1000 -> index=0x040, tag=0x000. Read miss with shared_in=1 -> way 0, mesi_out=S, evict=0.
  - Repeat the read -> hit=1, state still S.
- address=0x0000_2000 (index 0x080) write miss -> mesi_out=M. Snoop-read the same address -> hit=1, writeback=1, state S.
- address=0xFFFF_8000 -> index=0x3E00, tag=0xFFF. Read with shared_in=0 -> E; invalidate -> I, valid=0; read again -> miss.
- address=0x0000_3000 read with shared_in=1 -> S; write the same address -> hit=1, mesi_out=M.
- Fill set 0x040 with 16 distinct tags (all E), touch way 0, then a 17th tag misses.
  - Required: evict=1, writeback=0, victim way equals the PLRU choice (way 8), and way 0 is retained.
